// File: rtl/cordic_muldiv_pipe.sv
// cordic_muldiv_pipe: fully pipelined linear-mode CORDIC multiply / divide unit.
//   One CORDIC iteration per pipeline stage: input register, ITER iteration
//   stages, output register. Latency ITER+2, throughput one op per cycle.
//   A global stall freezes every stage while the output is held.
//   Multiply: result = round(a * b / 2^(WIDTH-1)), b in Q1.(WIDTH-1).
//   Divide:   result = b / a in Q(WIDTH+1).(WIDTH-1), ovf when out of range.
// Configuration macro: CORDIC_DIV_EN. When it is undefined, divide mode is not
//   built, mode_i is ignored and ovf_o is tied low.
// Ports:
//   clk_i, aresetn_i    clock, async active-low reset
//   valid_i / ready_o   input handshake; ready_o = ~valid_o | ready_i
//   mode_i              0 = multiply, 1 = divide
//   a_i, b_i            signed operands (WIDTH bits)
//   valid_o / ready_i   output handshake
//   result_o            signed result (2*WIDTH bits)
//   ovf_o               divide out of range, qualified by valid_o
// Legal ITER range is 4..WIDTH.
module cordic_muldiv_pipe #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned ITER  = WIDTH
) (
  input  logic                 clk_i,
  input  logic                 aresetn_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic                 mode_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ovf_o
);

  localparam int unsigned DW = 2*WIDTH + 2;  // two guard bits over the result width
  localparam int unsigned FB = WIDTH - 1;    // fraction bits of the aligned operands
  localparam logic [DW-1:0] HALF = DW'(1) << (FB - 1);

  typedef struct packed {
    logic                 mode;
    logic                 ovf;
    logic signed [DW-1:0] x;
    logic signed [DW-1:0] y;
    logic signed [DW-1:0] z;
  } stage_t;

  stage_t stage_q [0:ITER];
  logic   vld_q   [0:ITER];
  stage_t in_d;

  logic                 out_vld_q;
  logic                 out_ovf_q;
  logic [2*WIDTH-1:0]   out_res_q;
  logic                 adv_c;

  logic signed [DW-1:0] a_ext_c;
  logic signed [DW-1:0] b_ext_c;

  // Global stall: everything advances unless a result is waiting for the sink.
  assign adv_c   = ~out_vld_q | ready_i;
  assign ready_o = adv_c;

  assign a_ext_c = DW'($signed(a_i));
  assign b_ext_c = DW'($signed(b_i));

`ifdef CORDIC_DIV_EN
  logic signed [DW-1:0] abs_a_c;
  logic signed [DW-1:0] abs_b_c;
  logic                 div_ovf_c;

  // Quotient must satisfy |b/a| < 2 to fit the z accumulator range.
  assign abs_a_c   = a_ext_c[DW-1] ? -a_ext_c : a_ext_c;
  assign abs_b_c   = b_ext_c[DW-1] ? -b_ext_c : b_ext_c;
  assign div_ovf_c = (a_ext_c == '0) | (abs_b_c >= (abs_a_c <<< 1));
`else
  logic unused_mode;
  assign unused_mode = mode_i;
`endif

  // Input stage: align operands and load the CORDIC registers for the mode.
  always_comb begin
    in_d   = '0;
    in_d.x = a_ext_c <<< FB;
    in_d.z = b_ext_c;
`ifdef CORDIC_DIV_EN
    in_d.mode = mode_i;
    if (mode_i) begin
      in_d.y   = b_ext_c <<< FB;
      in_d.z   = '0;
      in_d.ovf = div_ovf_c;
    end
`endif
  end

  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      stage_q[0] <= '0;
      vld_q[0]   <= 1'b0;
    end else if (adv_c) begin
      stage_q[0] <= in_d;
      vld_q[0]   <= valid_i;
    end
  end

  // One linear-mode CORDIC iteration per stage.
  for (genvar i = 0; i < int'(ITER); i++) begin : g_iter
    localparam logic [DW-1:0] STEP = DW'(1) << (FB - i);

    stage_t               cur_c;
    stage_t               nxt_d;
    logic signed [DW-1:0] xs_c;

    assign cur_c = stage_q[i];
    assign xs_c  = $signed(cur_c.x) >>> i;

    always_comb begin
      nxt_d = cur_c;
`ifdef CORDIC_DIV_EN
      if (cur_c.mode) begin
        // Drive y toward zero; z accumulates the quotient.
        if (cur_c.y[DW-1] == cur_c.x[DW-1]) begin
          nxt_d.y = cur_c.y - xs_c;
          nxt_d.z = cur_c.z + STEP;
        end else begin
          nxt_d.y = cur_c.y + xs_c;
          nxt_d.z = cur_c.z - STEP;
        end
      end else
`endif
      begin
        // Drive z toward zero; y accumulates the product.
        if (!cur_c.z[DW-1]) begin
          nxt_d.y = cur_c.y + xs_c;
          nxt_d.z = cur_c.z - STEP;
        end else begin
          nxt_d.y = cur_c.y - xs_c;
          nxt_d.z = cur_c.z + STEP;
        end
      end
    end

    always_ff @(posedge clk_i or negedge aresetn_i) begin
      if (!aresetn_i) begin
        stage_q[i+1] <= '0;
        vld_q[i+1]   <= 1'b0;
      end else if (adv_c) begin
        stage_q[i+1] <= nxt_d;
        vld_q[i+1]   <= vld_q[i];
      end
    end
  end

  stage_t               last_c;
  logic signed [DW-1:0] mul_rnd_c;
  logic [2*WIDTH-1:0]   res_d;
  logic                 ovf_d;

  assign last_c    = stage_q[ITER];
  // Half-up rounding of the product to an integer.
  assign mul_rnd_c = $signed(last_c.y + HALF) >>> FB;

  always_comb begin
    res_d = mul_rnd_c[2*WIDTH-1:0];
    ovf_d = 1'b0;
`ifdef CORDIC_DIV_EN
    if (last_c.mode) begin
      ovf_d = last_c.ovf;
      res_d = last_c.ovf ? '0 : last_c.z[2*WIDTH-1:0];
    end
`endif
  end

  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      out_vld_q <= 1'b0;
      out_ovf_q <= 1'b0;
      out_res_q <= '0;
    end else if (adv_c) begin
      out_vld_q <= vld_q[ITER];
      if (vld_q[ITER]) begin
        out_res_q <= res_d;
        out_ovf_q <= ovf_d;
      end
    end
  end

  assign valid_o  = out_vld_q;
  assign result_o = out_res_q;
  assign ovf_o    = out_ovf_q;

  // Guard bits, x and (in multiply-only builds) z of the last stage are not needed.
  logic unused_bits;
  assign unused_bits = ^{last_c, mul_rnd_c};

endmodule

// File: tb/tb_cordic_muldiv_pipe.sv
// Directed self-checking bench for cordic_muldiv_pipe (WIDTH=16, ITER=16).
`timescale 1ns/1ps
module tb_cordic_muldiv_pipe;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned ITER  = 16;
  localparam int          LAT   = ITER + 2;
`ifdef CORDIC_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic               clk_i = 1'b0;
  logic               aresetn_i;
  logic               valid_i;
  logic               ready_o;
  logic               mode_i;
  logic [WIDTH-1:0]   a_i;
  logic [WIDTH-1:0]   b_i;
  logic               valid_o;
  logic               ready_i;
  logic [2*WIDTH-1:0] result_o;
  logic               ovf_o;

  int tests = 0;
  int fails = 0;

  always #5 clk_i = ~clk_i;

  cordic_muldiv_pipe #(.WIDTH(WIDTH), .ITER(ITER)) dut (
    .clk_i     (clk_i),
    .aresetn_i (aresetn_i),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .mode_i    (mode_i),
    .a_i       (a_i),
    .b_i       (b_i),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .result_o  (result_o),
    .ovf_o     (ovf_o)
  );

  // Ideal arithmetic for the streaming scoreboard.
  function automatic void model(input logic m, input int a, input int b,
                                output longint e, output longint tol, output logic ov);
    longint aa;
    longint ab;
    aa = (a < 0) ? -longint'(a) : longint'(a);
    ab = (b < 0) ? -longint'(b) : longint'(b);
    ov = 1'b0;
    if (m && DIV_EN) begin
      ov = (a == 0) || (ab >= 2 * aa);
      if (ov) begin
        e = 0; tol = 0;
      end else begin
        e   = longint'($floor(real'(longint'(b) * 32768) / real'(a) + 0.5));
        tol = 1;
      end
    end else begin
      e   = (longint'(a) * longint'(b) + 16384) >>> 15;
      tol = 1 + (aa >>> 15);
    end
  endfunction

  // Issue one op with ready_i high and wait for its result (bounded).
  task automatic run_op(input logic m, input int a, input int b,
                        output logic signed [31:0] res, output logic ov, output int lat);
    mode_i = m; a_i = 16'(a); b_i = 16'(b); valid_i = 1'b1; ready_i = 1'b1;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    lat = 1;
    while (!valid_o && lat < 100) begin
      @(posedge clk_i); #1;
      lat++;
    end
    res = result_o;
    ov  = ovf_o;
    @(posedge clk_i); #1;
  endtask

  task automatic test_reset();
    aresetn_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0; mode_i = 1'b0; a_i = '0; b_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    tests++;
    if (valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b need 0", valid_o); end
    tests++;
    if (result_o !== 32'd0) begin fails++; $display("FAIL reset_result: got %h need 0", result_o); end
    tests++;
    if (ovf_o !== 1'b0) begin fails++; $display("FAIL reset_ovf: got %b need 0", ovf_o); end
    aresetn_i = 1'b1;
    @(posedge clk_i); #1;
    tests++;
    if (ready_o !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b need 1", ready_o); end
    ready_i = 1'b1;
  endtask

  task automatic test_multiply();
    int a_t   [7] = '{100, -32768, 1000, -300, 32767, 0, -32768};
    int b_t   [7] = '{16384, -32768, 8192, 24576, 32767, 7, 32767};
    int e_t   [7] = '{50, 32768, 250, -225, 32766, 0, -32767};
    int tol_t [7] = '{1, 2, 1, 1, 1, 1, 2};
    logic signed [31:0] res;
    logic ov;
    int lat;
    int d;
    for (int k = 0; k < 7; k++) begin
      run_op(1'b0, a_t[k], b_t[k], res, ov, lat);
      d = int'(res) - e_t[k];
      tests++;
      if (d > tol_t[k] || d < -tol_t[k]) begin
        fails++;
        $display("FAIL mul_%0d (%0d*%0d): got %0d need %0d+-%0d", k, a_t[k], b_t[k], res, e_t[k], tol_t[k]);
      end
      tests++;
      if (ov !== 1'b0) begin fails++; $display("FAIL mul_ovf_%0d: got %b need 0", k, ov); end
      if (k == 0) begin
        tests++;
        if (lat != LAT) begin fails++; $display("FAIL mul_latency: got %0d need %0d", lat, LAT); end
      end
    end
  endtask

`ifdef CORDIC_DIV_EN
  task automatic test_divide();
    int a_t   [10] = '{1000, -1000, 100, -32768, 7, -32768, 100, 0, 100, 100};
    int b_t   [10] = '{500, 500, 199, 32767, -13, -32768, 250, 7, 200, -200};
    int e_t   [10] = '{16384, -16384, 65208, -32767, -60855, 32768, 0, 0, 0, 0};
    logic o_t [10] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1};
    logic signed [31:0] res;
    logic ov;
    int lat;
    int d;
    for (int k = 0; k < 10; k++) begin
      run_op(1'b1, a_t[k], b_t[k], res, ov, lat);
      tests++;
      if (ov !== o_t[k]) begin fails++; $display("FAIL div_ovf_%0d (%0d/%0d): got %b need %b", k, b_t[k], a_t[k], ov, o_t[k]); end
      d = int'(res) - e_t[k];
      tests++;
      if (o_t[k] ? (res !== 32'sd0) : (d > 1 || d < -1)) begin
        fails++;
        $display("FAIL div_%0d (%0d/%0d): got %0d need %0d", k, b_t[k], a_t[k], res, e_t[k]);
      end
      if (k == 0) begin
        tests++;
        if (lat != LAT) begin fails++; $display("FAIL div_latency: got %0d need %0d", lat, LAT); end
      end
    end
  endtask
`else
  task automatic test_mode_ignored();
    logic signed [31:0] res;
    logic ov;
    int lat;
    int d;
    run_op(1'b1, 100, 16384, res, ov, lat);
    d = int'(res) - 50;
    tests++;
    if (d > 1 || d < -1) begin fails++; $display("FAIL mode_ignored_result: got %0d need 50+-1", res); end
    tests++;
    if (ov !== 1'b0) begin fails++; $display("FAIL mode_ignored_ovf: got %b need 0", ov); end
    run_op(1'b1, 0, 7, res, ov, lat);
    tests++;
    if (res !== 32'sd0 || ov !== 1'b0) begin fails++; $display("FAIL mode_ignored_zero: got %0d/%b need 0/0", res, ov); end
  endtask
`endif

  task automatic test_back_to_back();
    logic m_t [8] = '{0, 1, 0, 1, 1, 0, 1, 0};
    int   a_t [8] = '{100, 1000, -32768, -1000, 100, -300, 0, 32767};
    int   b_t [8] = '{16384, 500, -32768, 500, 250, 24576, 7, 32767};
    longint e_q [$];
    longint t_q [$];
    logic   o_q [$];
    longint e, t, d;
    logic   ov;
    int sent = 0;
    int got = 0;
    int cyc = 0;
    int extra = 0;
    logic [31:0] held_res = '0;
    logic held_ov = 1'b0;
    logic stalled_prev = 1'b0;
    while (got < 8 && cyc < 200) begin
      ready_i = !(cyc >= 20 && cyc < 25);
      if (sent < 8) begin
        valid_i = 1'b1; mode_i = m_t[sent]; a_i = 16'(a_t[sent]); b_i = 16'(b_t[sent]);
      end else begin
        valid_i = 1'b0;
      end
      #1;
      if (valid_o && ready_i) begin
        tests++;
        if (e_q.size() == 0) begin
          fails++;
          $display("FAIL stream_extra: got unexpected result %0d", $signed(result_o));
        end else begin
          e = e_q.pop_front(); t = t_q.pop_front(); ov = o_q.pop_front();
          d = longint'($signed(result_o)) - e;
          if (d > t || d < -t || ovf_o !== ov) begin
            fails++;
            $display("FAIL stream_%0d: got %0d/%b need %0d+-%0d/%b", got, $signed(result_o), ovf_o, e, t, ov);
          end
        end
        got++;
      end
      if (valid_o && !ready_i) begin
        tests++;
        if (ready_o !== 1'b0) begin fails++; $display("FAIL stall_ready: got %b need 0", ready_o); end
        if (stalled_prev) begin
          tests++;
          if (result_o !== held_res || ovf_o !== held_ov) begin
            fails++;
            $display("FAIL stall_hold: got %h/%b need %h/%b", result_o, ovf_o, held_res, held_ov);
          end
        end
        held_res = result_o; held_ov = ovf_o; stalled_prev = 1'b1;
      end else begin
        stalled_prev = 1'b0;
      end
      if (valid_i && ready_o) begin
        model(m_t[sent], a_t[sent], b_t[sent], e, t, ov);
        e_q.push_back(e); t_q.push_back(t); o_q.push_back(ov);
        sent++;
      end
      @(posedge clk_i); #1;
      cyc++;
    end
    valid_i = 1'b0; ready_i = 1'b1;
    tests++;
    if (got != 8) begin fails++; $display("FAIL stream_count: got %0d need 8", got); end
    repeat (LAT + 4) begin
      if (valid_o) extra++;
      @(posedge clk_i); #1;
    end
    tests++;
    if (extra != 0) begin fails++; $display("FAIL stream_duplicate: got %0d extra results need 0", extra); end
  endtask

  task automatic test_reset_midflight();
    int wait_cyc = 0;
    int stale = 0;
    logic signed [31:0] res;
    logic ov;
    int lat;
    int d;
    ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      valid_i = 1'b1; mode_i = 1'b0; a_i = 16'(100 * (k + 1)); b_i = 16'h4000;
      @(posedge clk_i); #1;
    end
    valid_i = 1'b0;
    ready_i = 1'b0;
    while (!valid_o && wait_cyc < 40) begin
      @(posedge clk_i); #1;
      wait_cyc++;
    end
    tests++;
    if (valid_o !== 1'b1) begin fails++; $display("FAIL midflight_setup: got valid_o %b need 1", valid_o); end
    #2;
    aresetn_i = 1'b0;
    #1;
    tests++;
    if (valid_o !== 1'b0) begin fails++; $display("FAIL midflight_valid: got %b need 0", valid_o); end
    tests++;
    if (result_o !== 32'd0) begin fails++; $display("FAIL midflight_result: got %h need 0", result_o); end
    repeat (2) @(posedge clk_i);
    #3;
    aresetn_i = 1'b1;
    ready_i = 1'b1;
    @(posedge clk_i); #1;
    repeat (LAT + 8) begin
      if (valid_o) stale++;
      @(posedge clk_i); #1;
    end
    tests++;
    if (stale != 0) begin fails++; $display("FAIL midflight_stale: got %0d results need 0", stale); end
    run_op(1'b0, 1000, 8192, res, ov, lat);
    d = int'(res) - 250;
    tests++;
    if (d > 1 || d < -1 || ov !== 1'b0) begin fails++; $display("FAIL midflight_next: got %0d/%b need 250+-1/0", res, ov); end
    tests++;
    if (lat != LAT) begin fails++; $display("FAIL midflight_latency: got %0d need %0d", lat, LAT); end
  endtask

  initial begin
    test_reset();
    test_multiply();
`ifdef CORDIC_DIV_EN
    test_divide();
`else
    test_mode_ignored();
`endif
    test_back_to_back();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
